// File: rtl/sram_arb_pkg.sv
// Shared types and width helpers for the SRAM port arbiter.
// Response metadata carries a fixed-width port index so one struct serves any NUM_PORTS <= 256.
package sram_arb_pkg;

   localparam int unsigned PORT_IDX_W = 8;

   typedef struct packed {
      logic                  valid;
      logic [PORT_IDX_W-1:0] port;
      logic                  is_read;
   } resp_meta_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned byte_w(input int unsigned dw);
      return (dw + 7) / 8;
   endfunction

endpackage

// File: rtl/sram_rr_picker.sv
// Combinational round-robin picker: rotate requests by the pointer, take the lowest set bit,
// rotate the index back. Produces a one-hot grant plus the binary winner index.
module sram_rr_picker #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_valid
);

   logic [N-1:0] w_rot;
   int           w_first;
   int           w_k;

   always_comb begin
      w_rot   = '0;
      w_first = 0;
      w_k     = 0;
      o_gnt   = '0;
      o_valid = |i_req;
      for (int j = 0; j < int'(N); j++) begin
         w_k = j + int'(i_ptr);
         if (w_k >= int'(N)) w_k = w_k - int'(N);
         w_rot[j] = i_req[IW'(w_k)];
      end
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (w_rot[i]) w_first = i;
      end
      w_k = w_first + int'(i_ptr);
      if (w_k >= int'(N)) w_k = w_k - int'(N);
      o_idx = IW'(w_k);
      if (o_valid) o_gnt[o_idx] = 1'b1;
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency SRAM between NUM_PORTS requesters.
// Define SRAM_ARB_OUT_REG_EN to register the response outputs (2-cycle response latency).
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 1,
   parameter int unsigned NUM_WORDS  = 1024,
   localparam int unsigned AW = clog2_min1(NUM_WORDS),
   localparam int unsigned BW = byte_w(DATA_WIDTH),
   localparam int unsigned IW = clog2_min1(NUM_PORTS)
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic [NUM_PORTS-1:0]             req_i,
   input  logic [NUM_PORTS-1:0]             we_i,
   input  logic [NUM_PORTS*AW-1:0]          addr_i,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata_i,
   input  logic [NUM_PORTS*USER_WIDTH-1:0]  wuser_i,
   input  logic [NUM_PORTS*BW-1:0]          be_i,
   output logic [NUM_PORTS-1:0]             gnt_o,
   output logic [NUM_PORTS-1:0]             rvalid_o,
   output logic [DATA_WIDTH-1:0]            rdata_o,
   output logic [USER_WIDTH-1:0]            ruser_o,
   output logic                             sram_req_o,
   output logic                             sram_we_o,
   output logic [AW-1:0]                    sram_addr_o,
   output logic [DATA_WIDTH-1:0]            sram_wdata_o,
   output logic [USER_WIDTH-1:0]            sram_wuser_o,
   output logic [BW-1:0]                    sram_be_o,
   input  logic [DATA_WIDTH-1:0]            sram_rdata_i,
   input  logic [USER_WIDTH-1:0]            sram_ruser_i
);

   logic [NUM_PORTS-1:0] w_req;
   logic [NUM_PORTS-1:0] w_gnt;
   logic [IW-1:0]        w_idx;
   logic                 w_any;
   logic [IW-1:0]        r_rr_q;
   resp_meta_t           w_resp_d;
   resp_meta_t           r_resp_q;
   resp_meta_t           w_resp_out;

   // Requests are masked while in reset so grants and SRAM strobes stay low.
   assign w_req = rst_ni ? req_i : '0;

   sram_rr_picker #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_picker (
      .i_req   (w_req),
      .i_ptr   (r_rr_q),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_any)
   );

   assign gnt_o      = w_gnt;
   assign sram_req_o = w_any;

   always_comb begin
      sram_we_o    = 1'b0;
      sram_addr_o  = '0;
      sram_wdata_o = '0;
      sram_wuser_o = '0;
      sram_be_o    = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (w_any && (w_idx == IW'(i))) begin
            sram_we_o    = we_i[i];
            sram_addr_o  = addr_i[i*AW +: AW];
            sram_wdata_o = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            sram_wuser_o = wuser_i[i*USER_WIDTH +: USER_WIDTH];
            sram_be_o    = be_i[i*BW +: BW];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_q <= '0;
      end else if (w_any) begin
         r_rr_q <= (w_idx == IW'(NUM_PORTS - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   always_comb begin
      w_resp_d.valid   = w_any;
      w_resp_d.port    = PORT_IDX_W'(w_idx);
      w_resp_d.is_read = ~sram_we_o;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_resp_q <= '0;
      end else begin
         r_resp_q <= w_resp_d;
      end
   end

`ifdef SRAM_ARB_OUT_REG_EN
   resp_meta_t            r_resp2_q;
   logic [DATA_WIDTH-1:0] r_rdata_q;
   logic [USER_WIDTH-1:0] r_ruser_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_resp2_q <= '0;
         r_rdata_q <= '0;
         r_ruser_q <= '0;
      end else begin
         r_resp2_q <= r_resp_q;
         r_rdata_q <= (r_resp_q.valid && r_resp_q.is_read) ? sram_rdata_i : '0;
         r_ruser_q <= (r_resp_q.valid && r_resp_q.is_read) ? sram_ruser_i : '0;
      end
   end

   assign w_resp_out = r_resp2_q;
   assign rdata_o    = r_rdata_q;
   assign ruser_o    = r_ruser_q;
`else
   assign w_resp_out = r_resp_q;
   assign rdata_o    = (r_resp_q.valid && r_resp_q.is_read) ? sram_rdata_i : '0;
   assign ruser_o    = (r_resp_q.valid && r_resp_q.is_read) ? sram_ruser_i : '0;
`endif

   always_comb begin
      rvalid_o = '0;
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
         if (w_resp_out.valid && (w_resp_out.port == PORT_IDX_W'(i))) rvalid_o[i] = 1'b1;
      end
   end

endmodule
